// File: rtl/dma_line_engine.sv
// Multi-channel line-transfer engine: round-robin arbitration over NUM_CH requesters,
// a DEPTH_LINES-line backing store with fixed latency, one whole line per transaction.
//
// state  | meaning
// S_IDLE | arbitrate pending channels; served channel masked for one cycle after RESP
// S_BUSY | latency countdown; store write/read on the edge where cnt reaches zero
// S_RESP | one-cycle fill_valid_o / evict_ack_o pulse for the latched channel
module dma_line_engine #(
    parameter int NUM_CH      = 2,
    parameter int LINE_BITS   = 512,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LINES = 1024,
    parameter int MEM_LATENCY = 4,
    parameter     INIT_FILE   = ""
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_CH-1:0]           req_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_CH-1:0]           evict_valid_i,
    input  logic [NUM_CH*ADDR_W-1:0]    evict_addr_i,
    input  logic [NUM_CH*LINE_BITS-1:0] evict_data_i,
    output logic [NUM_CH-1:0]           fill_valid_o,
    output logic [LINE_BITS-1:0]        fill_data_o,
    output logic [ADDR_W-1:0]           fill_addr_o,
    output logic [NUM_CH-1:0]           evict_ack_o,
    output logic                        busy_o
);

    localparam int OFS  = $clog2(LINE_BITS / 8);
    localparam int IDXW = $clog2(DEPTH_LINES);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFS;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CHW-1:0]        r_rr_ptr;
    logic [CHW-1:0]        r_ch;
    logic                  r_mask_vld;
    logic                  r_is_evict;
    logic [IDXW-1:0]       r_idx;
    logic [ADDR_W-1:0]     r_addr;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_mem [DEPTH_LINES];

    logic                  w_gnt_vld;
    logic [CHW-1:0]        w_gnt_ch;
    logic                  w_gnt_evict;
    logic [ADDR_W-1:0]     w_gnt_addr;
    logic [LINE_BITS-1:0]  w_gnt_data;
    logic [CHW-1:0]        w_rr_next;
    logic                  w_mem_we;

    // Scan downward in offset so the lowest offset from rr_ptr wins.
    always_comb begin
        int c;
        c         = 0;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (int'(r_rr_ptr) + i) % NUM_CH;
            if ((evict_valid_i[c] || req_valid_i[c]) &&
                !(r_mask_vld && (CHW'(c) == r_ch))) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CHW'(c);
            end
        end
    end

    always_comb begin
        w_gnt_evict = evict_valid_i[w_gnt_ch];
        w_gnt_addr  = w_gnt_evict ? evict_addr_i[int'(w_gnt_ch)*ADDR_W +: ADDR_W]
                                  : req_addr_i[int'(w_gnt_ch)*ADDR_W +: ADDR_W];
        w_gnt_data  = evict_data_i[int'(w_gnt_ch)*LINE_BITS +: LINE_BITS];
        w_rr_next   = CHW'((int'(w_gnt_ch) + 1) % NUM_CH);
    end

    assign w_mem_we = (r_state == S_BUSY) && (r_cnt == '0) && r_is_evict;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[r_idx] <= r_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_ch         <= '0;
            r_mask_vld   <= 1'b0;
            r_is_evict   <= 1'b0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            fill_valid_o <= '0;
            evict_ack_o  <= '0;
            fill_data_o  <= '0;
            fill_addr_o  <= '0;
            busy_o       <= 1'b0;
        end else begin
            fill_valid_o <= '0;
            evict_ack_o  <= '0;
            case (r_state)
                S_IDLE: begin
                    r_mask_vld <= 1'b0;
                    if (w_gnt_vld) begin
                        r_state    <= S_BUSY;
                        busy_o     <= 1'b1;
                        r_ch       <= w_gnt_ch;
                        r_is_evict <= w_gnt_evict;
                        r_idx      <= w_gnt_addr[OFS+IDXW-1:OFS];
                        r_addr     <= w_gnt_addr & ALIGN_MASK;
                        r_rr_ptr   <= w_rr_next;
                        r_cnt      <= CW'(MEM_LATENCY - 1);
                        if (w_gnt_evict) r_wdata <= w_gnt_data;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        if (r_is_evict) begin
                            evict_ack_o[r_ch] <= 1'b1;
                        end else begin
                            fill_valid_o[r_ch] <= 1'b1;
                            fill_data_o        <= r_mem[r_idx];
                            fill_addr_o        <= r_addr;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    busy_o     <= 1'b0;
                    r_mask_vld <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_line_engine.sv
// Directed bench for dma_line_engine: expected responses are queued when stimulus is
// driven and popped/compared whenever a fill or evict pulse appears.
module tb_dma_line_engine;

    localparam int NUM_CH = 2;
    localparam int LB     = 512;
    localparam int AW     = 32;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic [NUM_CH-1:0]     req_valid_i = '0;
    logic [NUM_CH*AW-1:0]  req_addr_i = '0;
    logic [NUM_CH-1:0]     evict_valid_i = '0;
    logic [NUM_CH*AW-1:0]  evict_addr_i = '0;
    logic [NUM_CH*LB-1:0]  evict_data_i = '0;
    logic [NUM_CH-1:0]     fill_valid_o;
    logic [LB-1:0]         fill_data_o;
    logic [AW-1:0]         fill_addr_o;
    logic [NUM_CH-1:0]     evict_ack_o;
    logic                  busy_o;

    dma_line_engine #(
        .NUM_CH(NUM_CH), .LINE_BITS(LB), .ADDR_W(AW),
        .DEPTH_LINES(DEPTH), .MEM_LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i),
        .evict_data_i(evict_data_i),
        .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o),
        .fill_addr_o(fill_addr_o), .evict_ack_o(evict_ack_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string          tag;
        bit             is_evict;
        int             ch;
        logic [AW-1:0]  addr;
        logic [LB-1:0]  data;
        int             exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   auto_drop = 1'b1;

    localparam logic [LB-1:0] PAT_A = {64{8'hA5}};
    localparam logic [LB-1:0] PAT_B = {64{8'h3C}};
    localparam logic [LB-1:0] PAT_C = {16{32'hC0FFEE11}};
    localparam logic [LB-1:0] PAT_D = {16{32'hDEAD0123}};

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, retire any response against the queue head.
    task automatic step();
        exp_t e;
        logic [NUM_CH-1:0] v;
        @(posedge clk_i);
        #1;
        cyc++;
        if (fill_valid_o != '0 || evict_ack_o != '0) begin
            chk("unexpected_pulse", LB'(sb.size() != 0), LB'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                v = '0;
                v[e.ch] = 1'b1;
                chk({e.tag, "_fill_valid"}, LB'(fill_valid_o), e.is_evict ? '0 : LB'(v));
                chk({e.tag, "_evict_ack"}, LB'(evict_ack_o), e.is_evict ? LB'(v) : '0);
                if (!e.is_evict) begin
                    chk({e.tag, "_addr"}, LB'(fill_addr_o), LB'(e.addr));
                    chk({e.tag, "_data"}, fill_data_o, e.data);
                end
                if (e.exp_cyc >= 0) chk({e.tag, "_cycle"}, LB'(cyc), LB'(e.exp_cyc));
            end
            if (auto_drop) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (fill_valid_o[c]) req_valid_i[c] = 1'b0;
                    if (evict_ack_o[c])  evict_valid_i[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_empty(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        chk({tag, "_timeout"}, LB'(sb.size()), '0);
        sb.delete();
    endtask

    task automatic drive_fill(input string tag, input int c, input logic [AW-1:0] addr,
                              input logic [AW-1:0] exp_addr, input logic [LB-1:0] data,
                              input int exp_cyc);
        exp_t e;
        req_addr_i[c*AW +: AW] = addr;
        req_valid_i[c] = 1'b1;
        e.tag = tag; e.is_evict = 1'b0; e.ch = c; e.addr = exp_addr;
        e.data = data; e.exp_cyc = exp_cyc;
        sb.push_back(e);
    endtask

    task automatic drive_evict(input string tag, input int c, input logic [AW-1:0] addr,
                               input logic [LB-1:0] data, input int exp_cyc, input bit expect_ack);
        exp_t e;
        evict_addr_i[c*AW +: AW] = addr;
        evict_data_i[c*LB +: LB] = data;
        evict_valid_i[c] = 1'b1;
        e.tag = tag; e.is_evict = 1'b1; e.ch = c; e.addr = addr;
        e.data = data; e.exp_cyc = exp_cyc;
        if (expect_ack) sb.push_back(e);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_fill_valid"}, LB'(fill_valid_o), '0);
        chk({tag, "_evict_ack"}, LB'(evict_ack_o), '0);
        chk({tag, "_busy"}, LB'(busy_o), '0);
    endtask

    initial begin
        // Reset held with random inputs
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i   = NUM_CH'($urandom);
            evict_valid_i = NUM_CH'($urandom);
            req_addr_i    = {$urandom, $urandom};
            evict_addr_i  = {$urandom, $urandom};
            evict_data_i  = {32{$urandom}};
            step();
        end
        chk_quiet("rst_hold");
        chk("rst_fill_data", fill_data_o, '0);
        chk("rst_fill_addr", LB'(fill_addr_o), '0);
        req_valid_i = '0; evict_valid_i = '0;
        rst_n_i = 1'b1;
        idle(3);
        chk_quiet("rst_release");
        chk("rel_fill_data", fill_data_o, '0);

        // Evict then fill on ch0
        drive_evict("ev40", 0, 32'h40, PAT_A, cyc + LAT + 1, 1'b1);
        step();
        chk("ev40_busy_after_grant", LB'(busy_o), LB'(1));
        wait_empty("ev40", 20);
        chk("ev40_busy_in_resp", LB'(busy_o), LB'(1));
        step();
        chk("ev40_busy_after_resp", LB'(busy_o), '0);
        idle(2);
        drive_fill("fill40", 0, 32'h40, 32'h40, PAT_A, cyc + LAT + 1);
        wait_empty("fill40", 20);
        idle(3);

        // Same-channel evict and fill in one cycle: evict first, masked cycle, then fill
        drive_evict("ev80", 1, 32'h80, PAT_B, cyc + LAT + 1, 1'b1);
        drive_fill("fill80", 1, 32'h80, 32'h80, PAT_B, cyc + 2*LAT + 4);
        wait_empty("order80", 40);
        idle(3);

        // Offset bits ignored; upper bits alias modulo DEPTH lines
        drive_fill("fill47", 0, 32'h47, 32'h40, PAT_A, cyc + LAT + 1);
        wait_empty("fill47", 20);
        idle(3);
        drive_fill("alias", 1, 32'h40 + DEPTH*64, 32'h40 + DEPTH*64, PAT_A, cyc + LAT + 1);
        wait_empty("alias", 20);
        idle(3);

        // Evict leaves fill outputs untouched
        drive_evict("ev100", 0, 32'h100, PAT_D, cyc + LAT + 1, 1'b1);
        wait_empty("ev100", 20);
        chk("hold_fill_data", fill_data_o, PAT_A);
        chk("hold_fill_addr", LB'(fill_addr_o), LB'(32'h40 + DEPTH*64));
        idle(3);

        // Round robin from reset with both requests held
        rst_n_i = 1'b0;
        idle(2);
        rst_n_i = 1'b1;
        idle(1);
        auto_drop = 1'b0;
        drive_fill("rr0", 0, 32'h40, 32'h40, PAT_A, cyc + LAT + 1);
        drive_fill("rr1", 1, 32'h80, 32'h80, PAT_B, cyc + 2*LAT + 3);
        begin
            exp_t e;
            e = sb[0]; e.tag = "rr2"; e.exp_cyc = cyc + 3*LAT + 5; sb.push_back(e);
            e = sb[1]; e.tag = "rr3"; e.exp_cyc = cyc + 4*LAT + 7; sb.push_back(e);
        end
        wait_empty("rr", 60);
        req_valid_i = '0;
        auto_drop = 1'b1;
        idle(8);
        chk_quiet("rr_drained");

        // Reset mid-BUSY drops the evict; line keeps D
        drive_evict("ev_cut", 0, 32'h100, PAT_C, -1, 1'b0);
        idle(3);
        chk("cut_busy_before_rst", LB'(busy_o), LB'(1));
        rst_n_i = 1'b0;
        evict_valid_i = '0;
        #1;
        chk_quiet("cut_in_rst");
        idle(2);
        rst_n_i = 1'b1;
        idle(8);
        chk_quiet("cut_after_rst");
        drive_fill("fill100", 0, 32'h100, 32'h100, PAT_D, cyc + LAT + 1);
        wait_empty("fill100", 20);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
